// File: rtl/alu_operand_stage_if.sv
// Shared widths and the decode->execute operand bus between the operand stage and its neighbours.
package my_pkg;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;
endpackage

interface alu_operand_stage_if #(
  parameter int unsigned DATA_WIDTH = my_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = my_pkg::ADDR_WIDTH,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_FWD    = 2
);
  logic                          in_valid;
  logic                          in_ready;
  logic [ADDR_WIDTH-1:0]         pc;
  logic [REG_AW-1:0]             rs1_addr;
  logic [REG_AW-1:0]             rs2_addr;
  logic [DATA_WIDTH-1:0]         rs1_data;
  logic [DATA_WIDTH-1:0]         rs2_data;
  logic [DATA_WIDTH-1:0]         imm;
  logic [2:0]                    alu_src;
  logic [NUM_FWD-1:0]            fwd_valid;
  logic [NUM_FWD*REG_AW-1:0]     fwd_addr;
  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_data;
  logic                          flush;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         data1;
  logic [DATA_WIDTH-1:0]         data2;
  logic [DATA_WIDTH-1:0]         store_data;

  modport master (
    output in_valid, pc, rs1_addr, rs2_addr, rs1_data, rs2_data, imm, alu_src,
           fwd_valid, fwd_addr, fwd_data, flush, out_ready,
    input  in_ready, out_valid, data1, data2, store_data
  );

  modport slave (
    input  in_valid, pc, rs1_addr, rs2_addr, rs1_data, rs2_data, imm, alu_src,
           fwd_valid, fwd_addr, fwd_data, flush, out_ready,
    output in_ready, out_valid, data1, data2, store_data
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Registered ALU operand select with result forwarding and a 2-entry (main + skid) elastic buffer.
module alu_operand_stage #(
  parameter int unsigned DATA_WIDTH = my_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = my_pkg::ADDR_WIDTH,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_FWD    = 2
) (
  input logic               clk,
  input logic               rst_n,
  alu_operand_stage_if.slave bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data1;
    logic [DATA_WIDTH-1:0] data2;
    logic [DATA_WIDTH-1:0] store_data;
  } operand_t;

  operand_t main_q, main_d;
  operand_t skid_q, skid_d;
  logic     out_valid_q, out_valid_d;
  logic     skid_v_q, skid_v_d;
  logic     in_ready_q, in_ready_d;

  logic [DATA_WIDTH-1:0] rs1_fwd;
  logic [DATA_WIDTH-1:0] rs2_fwd;
  logic [ADDR_WIDTH-1:0] pc_w;
  operand_t              sel;
  logic                  accept;

  assign pc_w = bus.pc;

  // Forwarding: scan oldest to youngest so the lowest matching channel wins; x0 never forwards.
  always_comb begin
    rs1_fwd = bus.rs1_data;
    rs2_fwd = bus.rs2_data;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (bus.fwd_valid[i] && (bus.rs1_addr != '0) &&
          (bus.fwd_addr[i*REG_AW +: REG_AW] == bus.rs1_addr))
        rs1_fwd = bus.fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
      if (bus.fwd_valid[i] && (bus.rs2_addr != '0) &&
          (bus.fwd_addr[i*REG_AW +: REG_AW] == bus.rs2_addr))
        rs2_fwd = bus.fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Operand selection
  always_comb begin
    sel.data1      = bus.alu_src[0] ? DATA_WIDTH'(pc_w) : rs1_fwd;
    sel.store_data = rs2_fwd;
    case (bus.alu_src[2:1])
      2'b00:   sel.data2 = rs2_fwd;
      2'b01:   sel.data2 = bus.imm;
      2'b10:   sel.data2 = DATA_WIDTH'(4);
      default: sel.data2 = '0;
    endcase
  end

  assign accept = bus.in_valid && in_ready_q && !bus.flush;

  // Elastic buffer next state; accept implies the skid is empty because in_ready tracks !skid_v.
  always_comb begin
    main_d      = main_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    skid_v_d    = skid_v_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
      skid_v_d    = 1'b0;
    end else if (accept) begin
      if (!out_valid_q || bus.out_ready) begin
        main_d      = sel;
        out_valid_d = 1'b1;
      end else begin
        skid_d   = sel;
        skid_v_d = 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    in_ready_d = !skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_v_q    <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      skid_v_q    <= skid_v_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.data1      = main_q.data1;
  assign bus.data2      = main_q.data2;
  assign bus.store_data = main_q.store_data;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed vector table plus hand sequences for reset, backpressure and flush on alu_operand_stage.
module tb_alu_operand_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [2:0]  src;
    logic [1:0]  fv;
    logic [9:0]  fa;
    logic [63:0] fd;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] es;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.rs1_addr  = v.a1;
    bus.rs2_addr  = v.a2;
    bus.rs1_data  = v.r1;
    bus.rs2_data  = v.r2;
    bus.imm       = v.imm;
    bus.pc        = v.pc;
    bus.alu_src   = v.src;
    bus.fwd_valid = v.fv;
    bus.fwd_addr  = v.fa;
    bus.fwd_data  = v.fd;
  endtask

  // Simple entry carrying a tag in rs1_data; data1 echoes the tag with alu_src=000.
  function automatic vec_t tag(input logic [31:0] t);
    vec_t v;
    v = '{5'd1, 5'd2, t, 32'h20, 32'h0, 32'h1000, 3'b000, 2'b00, 10'd0, 64'd0, t, 32'h20, 32'h20};
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    vecs[0] = '{5'd1, 5'd2, 32'h10, 32'h20, 32'hFFFFFFF0, 32'h1000, 3'b000, 2'b00, 10'd0, 64'd0,
                32'h10, 32'h20, 32'h20};
    vecs[1] = '{5'd1, 5'd2, 32'h10, 32'h20, 32'hFFFFFFF0, 32'h1000, 3'b011, 2'b00, 10'd0, 64'd0,
                32'h1000, 32'hFFFFFFF0, 32'h20};
    vecs[2] = '{5'd1, 5'd2, 32'h10, 32'h20, 32'hFFFFFFF0, 32'h1000, 3'b101, 2'b00, 10'd0, 64'd0,
                32'h1000, 32'h4, 32'h20};
    vecs[3] = '{5'd1, 5'd2, 32'h10, 32'h20, 32'hFFFFFFF0, 32'h1000, 3'b111, 2'b00, 10'd0, 64'd0,
                32'h1000, 32'h0, 32'h20};
    // Both channels hit rs1=5: channel 0 must win.
    vecs[4] = '{5'd5, 5'd2, 32'h10, 32'h20, 32'hFFFFFFF0, 32'h1000, 3'b000, 2'b11,
                {5'd5, 5'd5}, {32'hBBBB, 32'hAAAA}, 32'hAAAA, 32'h20, 32'h20};
    // x0 is never forwarded.
    vecs[5] = '{5'd0, 5'd2, 32'h10, 32'h20, 32'hFFFFFFF0, 32'h1000, 3'b000, 2'b01,
                {5'd0, 5'd0}, {32'hBBBB, 32'hAAAA}, 32'h10, 32'h20, 32'h20};
    // Store data forwarded while data2 takes the immediate.
    vecs[6] = '{5'd1, 5'd7, 32'h10, 32'h20, 32'hFFFFFFF0, 32'h1000, 3'b010, 2'b10,
                {5'd7, 5'd0}, {32'h55, 32'h0}, 32'h10, 32'hFFFFFFF0, 32'h55};
    // Address match on invalid channel 0 is ignored; channel 1 supplies rs1.
    vecs[7] = '{5'd3, 5'd2, 32'h10, 32'h20, 32'hFFFFFFF0, 32'h1000, 3'b000, 2'b10,
                {5'd3, 5'd3}, {32'hBBBB, 32'hAAAA}, 32'hBBBB, 32'h20, 32'h20};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(vecs[0]);

    // Reset held two cycles with a valid input present
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
      chk("rst_data1", bus.data1, 32'h0);
      chk("rst_data2", bus.data2, 32'h0);
      chk("rst_store", bus.store_data, 32'h0);
    end

    // Vector table streamed at full throughput
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(vecs[k]);
      step();
      chk($sformatf("v%0d_out_valid", k), 32'(bus.out_valid), 32'h1);
      chk($sformatf("v%0d_data1", k), bus.data1, vecs[k].e1);
      chk($sformatf("v%0d_data2", k), bus.data2, vecs[k].e2);
      chk($sformatf("v%0d_store", k), bus.store_data, vecs[k].es);
    end
    bus.in_valid = 1'b0;
    step();
    chk("drain_out_valid", 32'(bus.out_valid), 32'h0);

    // Backpressure: A to main, B to skid, C held upstream
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(tag(32'hA1));
    step();
    chk("bp_a_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_a_data", bus.data1, 32'hA1);
    chk("bp_a_ready", 32'(bus.in_ready), 32'h1);
    drive(tag(32'hB2));
    step();
    chk("bp_b_main", bus.data1, 32'hA1);
    chk("bp_b_ready", 32'(bus.in_ready), 32'h0);
    drive(tag(32'hC3));
    step();
    chk("bp_c_hold", bus.data1, 32'hA1);
    chk("bp_c_ready", 32'(bus.in_ready), 32'h0);
    bus.out_ready = 1'b1;
    step();
    chk("bp_out_b", bus.data1, 32'hB2);
    chk("bp_out_b_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_ready_back", 32'(bus.in_ready), 32'h1);
    step();
    chk("bp_out_c", bus.data1, 32'hC3);
    chk("bp_out_c_valid", 32'(bus.out_valid), 32'h1);
    bus.in_valid = 1'b0;
    step();
    chk("bp_done_valid", 32'(bus.out_valid), 32'h0);

    // Flush with main and skid full and a new input presented
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(tag(32'hD4));
    step();
    drive(tag(32'hE5));
    step();
    chk("fl_full_ready", 32'(bus.in_ready), 32'h0);
    drive(tag(32'hF6));
    bus.flush = 1'b1;
    step();
    chk("fl_out_valid", 32'(bus.out_valid), 32'h0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'h1);
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("fl_no_ghost", 32'(bus.out_valid), 32'h0);
    end
    bus.in_valid = 1'b1;
    drive(tag(32'h77));
    step();
    chk("fl_after_valid", 32'(bus.out_valid), 32'h1);
    chk("fl_after_data", bus.data1, 32'h77);

    // Reset discards held entries mid-operation
    bus.out_ready = 1'b0;
    drive(tag(32'h88));
    step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'h1);
    chk("mid_rst_data1", bus.data1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered ALU operand stage for the decode→execute boundary. Selects `data1`/`data2` from register file, PC, immediate or constants, and resolves read-after-write hazards with a parametrised set of forwarding channels. Results are held in a 2-entry elastic buffer with a valid/ready handshake, so the stage runs at full throughput and its `in_ready` is registered. It replaces the combinational operand mux in front of the ALU.

## Interface
- `DATA_WIDTH`, 32, operand width (from `my_pkg`)
- `ADDR_WIDTH`, 32, PC width (from `my_pkg`)
- `REG_AW`, 5, register index width
- `NUM_FWD`, 2, number of forwarding channels; index 0 = youngest/highest priority
- `clk` in 1 — single clock, all logic on rising edge
- `rst_n` in 1 — synchronous, active-low reset
- `in_valid` in 1 — upstream request valid
- `in_ready` out 1 — stage can accept (registered)
- `pc` in ADDR_WIDTH — instruction PC
- `rs1_addr`, `rs2_addr` in REG_AW — source register indices
- `rs1_data`, `rs2_data` in DATA_WIDTH — register file read data
- `imm` in DATA_WIDTH — sign-extended immediate
- `alu_src` in 3 — operand select
- `fwd_valid` in NUM_FWD — channel i carries a valid result
- `fwd_addr` in NUM_FWD*REG_AW — channel i destination, slice [i*REG_AW +: REG_AW]
- `fwd_data` in NUM_FWD*DATA_WIDTH — channel i result, slice [i*DATA_WIDTH +: DATA_WIDTH]
- `flush` in 1 — drop all held and incoming entries
- `out_valid` out 1 — operands valid
- `out_ready` in 1 — downstream accepts
- `data1`, `data2` out DATA_WIDTH — ALU operands
- `store_data` out DATA_WIDTH — forwarded rs2, independent of `alu_src`

## Operation
- Forwarding per source: `src_fwd` = `fwd_data[i]` for the lowest i with `fwd_valid[i]` && `fwd_addr[i]`==`src_addr` && `src_addr`!=0. Otherwise `src_fwd` is the register file data. x0 is never forwarded.
- `data1` = `alu_src[0]` ? `pc[DATA_WIDTH-1:0]` (zero-extended if ADDR_WIDTH<DATA_WIDTH) : `rs1_fwd`.
- `data2` by `alu_src[2:1]`: 00 → `rs2_fwd`, 01 → `imm`, 10 → constant 4, 11 → constant 0. Constants are zero-extended to DATA_WIDTH.
- `store_data` = `rs2_fwd` always.
- Forwarding and selection are evaluated once, on the accept cycle. Buffered entries are not re-forwarded.
- Storage: main entry (drives outputs, flag `out_valid`) plus skid entry (flag `skid_v`). `in_ready` = !`skid_v`, registered.
- Accept = `in_valid` && `in_ready` && !`flush`. On accept:
  - if !`out_valid` || `out_ready`: load main, `out_valid`←1;
  - else: load skid, `skid_v`←1.
- No accept, `out_valid` && `out_ready`: if `skid_v`, then main←skid and `skid_v`←0; else `out_valid`←0.
- `flush` (priority over everything except reset): `out_valid`←0, `skid_v`←0, `in_ready`←1. An input presented that cycle is dropped. Data registers keep their values.
- Reset (`rst_n`=0 at edge): `out_valid`=0, `skid_v`=0, `in_ready`=1, `data1`=`data2`=`store_data`=0. Held entries are discarded mid-operation.

## Timing
- Latency: accept at edge N → `out_valid`=1 with operands after edge N; visible in cycle N+1.
- Throughput: 1 per cycle while `out_ready`=1.
- Backpressure: the first accept during a stall fills skid. `in_ready` falls the following cycle.
- `in_ready` rises one cycle after the skid drains into main.
- Outputs are stable while `out_valid`=1 && `out_ready`=0.
- No combinational path from `out_ready` or the forwarding inputs to any output.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `in_ready`=1 and all data 0 throughout; first accept after release appears 1 cycle later.
- Select modes: `rs1_data`=0x10, `rs2_data`=0x20, `imm`=0xFFFFFFF0, `pc`=0x1000; `alu_src`=000/011/101/111 → (0x10,0x20), (0x1000,0xFFFFFFF0), (0x1000,4), (0x1000,0).
- Forward priority: `rs1_addr`=5, `fwd_valid`=11, `fwd_addr`={5,5}, `fwd_data`={0xBBBB(ch1), 0xAAAA(ch0)} → `data1`=0xAAAA. With `rs1_addr`=0 and channel address 0 → `data1`=`rs1_data`.
- Store forward: `alu_src`=010, `rs2_addr`=7, ch1 valid addr 7 data 0x55 → `data2`=`imm`, `store_data`=0x55.
- Backpressure: stream A,B,C with `out_ready`=0 → A in main, B in skid, `in_ready`=0, C held upstream. Raise `out_ready` → outputs A, B, C on consecutive cycles, none lost or duplicated.
- Flush: main+skid full, assert `flush` with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and the dropped input never appears.
